// File: rtl/scr1_dma_pkg.sv
// Shared types for the TCM DMA engine: memory-interface enums (mirroring
// scr1_memif.svh), DMA mode/state enums and the address step.
package scr1_dma_pkg;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [1:0] {
    SCR1_DMA_FILL  = 2'd0,
    SCR1_DMA_CHECK = 2'd1,
    SCR1_DMA_COPY  = 2'd2
  } scr1_dma_mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StRdReq,
    StRdResp,
    StWrReq,
    StWrResp,
    StGap,
    StFin
  } scr1_dma_state_e;

  localparam int unsigned SCR1_DMA_ADDR_STEP = 4;

  // Encoding 3 is reserved and behaves as FILL.
  function automatic scr1_dma_mode_e scr1_dma_decode_mode(input logic [1:0] raw);
    case (raw)
      2'd1:    return SCR1_DMA_CHECK;
      2'd2:    return SCR1_DMA_COPY;
      default: return SCR1_DMA_FILL;
    endcase
  endfunction

endpackage

// File: rtl/scr1_tcm_dma.sv
// Word-granular fill/check/copy engine acting as a requester on an SCR1
// dmem-style interface. One transaction outstanding; req drops for one cycle
// between transactions.
module scr1_tcm_dma
  import scr1_dma_pkg::*;
#(
  parameter int unsigned AWIDTH = 32,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned LWIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cfg_start,
  input  logic [1:0]           cfg_mode,
  input  logic [AWIDTH-1:0]    cfg_src_addr,
  input  logic [AWIDTH-1:0]    cfg_dst_addr,
  input  logic [LWIDTH-1:0]    cfg_len,
  input  logic [31:0]          cfg_pattern,
  input  logic                 cfg_incr,
  output logic                 busy,
  output logic                 done,
  output logic                 bus_err,
  output logic                 mism,
  output logic [AWIDTH-1:0]    err_addr,
  output logic [LWIDTH-1:0]    mism_cnt,
  output logic                 dmem_req,
  input  logic                 dmem_req_ack,
  output type_scr1_mem_cmd_e   dmem_cmd,
  output type_scr1_mem_width_e dmem_width,
  output logic [AWIDTH-1:0]    dmem_addr,
  output logic [DWIDTH-1:0]    dmem_wdata,
  input  logic [DWIDTH-1:0]    dmem_rdata,
  input  type_scr1_mem_resp_e  dmem_resp
);

  localparam logic [AWIDTH-1:0] ADDR_MASK = ~AWIDTH'(3);
  localparam logic [AWIDTH-1:0] ADDR_INC  = AWIDTH'(SCR1_DMA_ADDR_STEP);

  scr1_dma_state_e    state_q, state_d;
  scr1_dma_mode_e     mode_q, mode_d;
  logic [AWIDTH-1:0]  src_q, src_d, dst_q, dst_d;
  logic [LWIDTH-1:0]  cnt_q, cnt_d;
  logic [31:0]        pat_q, pat_d;
  logic               incr_q, incr_d;
  logic               req_q, req_d;
  type_scr1_mem_cmd_e cmd_q, cmd_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  // Doubles as the COPY hold register.
  logic [DWIDTH-1:0]  wdata_q, wdata_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               bus_err_q, bus_err_d, mism_q, mism_d;
  logic [AWIDTH-1:0]  err_addr_q, err_addr_d;
  logic [LWIDTH-1:0]  mism_cnt_q, mism_cnt_d;

  logic               cpl;
  logic               first_err;
  logic [AWIDTH-1:0]  src_nxt, dst_nxt;
  logic [31:0]        pat_nxt;

  assign src_nxt   = src_q + ADDR_INC;
  assign dst_nxt   = dst_q + ADDR_INC;
  assign pat_nxt   = pat_q + 32'(incr_q);
  assign first_err = !(bus_err_q || mism_q);

  // Next-state, request sequencing and status update.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    src_d      = src_q;
    dst_d      = dst_q;
    cnt_d      = cnt_q;
    pat_d      = pat_q;
    incr_d     = incr_q;
    req_d      = req_q;
    cmd_d      = cmd_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    bus_err_d  = bus_err_q;
    mism_d     = mism_q;
    err_addr_d = err_addr_q;
    mism_cnt_d = mism_cnt_q;
    cpl        = 1'b0;

    unique case (state_q)
      StIdle, StFin: begin
        state_d = StIdle;
        if (cfg_start) begin
          mode_d     = scr1_dma_decode_mode(cfg_mode);
          src_d      = cfg_src_addr & ADDR_MASK;
          dst_d      = cfg_dst_addr & ADDR_MASK;
          cnt_d      = cfg_len;
          pat_d      = cfg_pattern;
          incr_d     = cfg_incr;
          bus_err_d  = 1'b0;
          mism_d     = 1'b0;
          err_addr_d = '0;
          mism_cnt_d = '0;
          if (cfg_len == '0) begin
            state_d = StFin;
          end else begin
            req_d = 1'b1;
            if (mode_d == SCR1_DMA_FILL) begin
              state_d = StWrReq;
              cmd_d   = SCR1_MEM_CMD_WR;
              addr_d  = dst_d;
              wdata_d = cfg_pattern;
            end else begin
              state_d = StRdReq;
              cmd_d   = SCR1_MEM_CMD_RD;
              addr_d  = (mode_d == SCR1_DMA_COPY) ? src_d : dst_d;
            end
          end
        end
      end
      StRdReq, StWrReq: begin
        if (dmem_req_ack) begin
          if (dmem_resp == SCR1_MEM_RESP_NOTRDY) begin
            req_d   = 1'b0;
            state_d = (state_q == StRdReq) ? StRdResp : StWrResp;
          end else begin
            cpl = 1'b1;
          end
        end
      end
      StRdResp, StWrResp: begin
        cpl = (dmem_resp != SCR1_MEM_RESP_NOTRDY);
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StFin;
        end else begin
          req_d   = 1'b1;
          state_d = (cmd_q == SCR1_MEM_CMD_WR) ? StWrReq : StRdReq;
        end
      end
      default: state_d = StIdle;
    endcase

    // Completion: prepare the next request's cmd/addr/wdata while req is low.
    if (cpl) begin
      req_d   = 1'b0;
      state_d = StGap;
      if (dmem_resp == SCR1_MEM_RESP_RDY_ER) begin
        bus_err_d = 1'b1;
        if (first_err) err_addr_d = addr_q;
        state_d = StFin;
      end else if (cmd_q == SCR1_MEM_CMD_RD && mode_q == SCR1_DMA_COPY) begin
        cmd_d   = SCR1_MEM_CMD_WR;
        addr_d  = dst_q;
        wdata_d = dmem_rdata;
      end else begin
        cnt_d = cnt_q - LWIDTH'(1);
        dst_d = dst_nxt;
        pat_d = pat_nxt;
        if (cmd_q == SCR1_MEM_CMD_RD) begin
          if (dmem_rdata != pat_q) begin
            mism_d = 1'b1;
            if (first_err) err_addr_d = addr_q;
            if (mism_cnt_q != '1) mism_cnt_d = mism_cnt_q + LWIDTH'(1);
          end
          addr_d = dst_nxt;
        end else if (mode_q == SCR1_DMA_COPY) begin
          src_d  = src_nxt;
          cmd_d  = SCR1_MEM_CMD_RD;
          addr_d = src_nxt;
        end else begin
          addr_d  = dst_nxt;
          wdata_d = pat_nxt;
        end
      end
    end

    busy_d = !(state_d inside {StIdle, StFin});
    done_d = (state_d == StFin);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      mode_q     <= SCR1_DMA_FILL;
      src_q      <= '0;
      dst_q      <= '0;
      cnt_q      <= '0;
      pat_q      <= '0;
      incr_q     <= 1'b0;
      req_q      <= 1'b0;
      cmd_q      <= SCR1_MEM_CMD_RD;
      addr_q     <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      bus_err_q  <= 1'b0;
      mism_q     <= 1'b0;
      err_addr_q <= '0;
      mism_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      incr_q     <= incr_d;
      req_q      <= req_d;
      cmd_q      <= cmd_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      bus_err_q  <= bus_err_d;
      mism_q     <= mism_d;
      err_addr_q <= err_addr_d;
      mism_cnt_q <= mism_cnt_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign bus_err    = bus_err_q;
  assign mism       = mism_q;
  assign err_addr   = err_addr_q;
  assign mism_cnt   = mism_cnt_q;
  assign dmem_req   = req_q;
  assign dmem_cmd   = cmd_q;
  assign dmem_width = SCR1_MEM_WIDTH_WORD;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;

endmodule
